// File: rtl/div_dispatch.sv
// ---------------------------------------------------------------------------
// div_dispatch
//
// Scheduler for an iterative signed divider. It buffers signed
// dividend/divisor pairs in a small FIFO and launches one division at a time
// on the divider's start/complete interface. Each quotient is captured and
// presented on a result port together with two status flags. Divide-by-zero
// and the most-negative / -1 overflow case are answered directly and never
// reach the divider.
//
// Handshake semantics (input and result ports alike): a transfer happens on a
// rising clock edge where valid and ready are both 1. Once this block raises
// out_valid, the valid bit and the quotient and flags stay unchanged until the
// transfer. in_ready does not depend on in_valid.
//
// Optional build macro: DIV_DISPATCH_STATS_EN adds the stat_ops / stat_dbz
// handshake counters. The default build leaves the macro undefined.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   in_valid      operand pair offered
//   in_ready      FIFO has room (0 while in reset)
//   in_dividend   signed dividend
//   in_divisor    signed divisor
//   out_valid     result held
//   out_ready     consumer accepts the result
//   out_quotient  signed quotient
//   out_dbz       divisor was zero
//   out_ovf       dividend was the minimum value and divisor was -1
//   div_start     one-cycle launch pulse to the divider
//   div_dividend  dividend operand to the divider
//   div_divisor   divisor operand to the divider
//   div_quotient  divider result
//   div_complete  divider idle / finished
//   stat_ops      (DIV_DISPATCH_STATS_EN) result handshakes, saturating
//   stat_dbz      (DIV_DISPATCH_STATS_EN) divide-by-zero handshakes, saturating
//   dbg_state     current FSM state, for observation only
// ---------------------------------------------------------------------------
module div_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic                  out_dbz,
  output logic                  out_ovf,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic                  div_complete,
`ifdef DIV_DISPATCH_STATS_EN
  output logic [31:0]           stat_ops,
  output logic [15:0]           stat_dbz,
`endif
  output logic [1:0]            dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Operand FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_dvd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dvs_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  // Holds in_ready low from the reset edge until the first edge after
  // reset is released.
  logic                  rst_done_q;

  state_t                state_q;
  logic                  out_valid_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_dvd;
  logic [DATA_WIDTH-1:0] head_dvs;
  logic                  head_dbz;
  logic                  head_ovf;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = rst_done_q && !fifo_full;
  assign push       = in_valid && in_ready;
  // Pop only from IDLE with no result pending. The count register was
  // updated at the previous edge, so a push in this cycle is not yet
  // visible here (no fall-through).
  assign pop        = (state_q == S_IDLE) && !fifo_empty && !out_valid_q;

  assign head_dvd = fifo_dvd_q[rd_ptr_q];
  assign head_dvs = fifo_dvs_q[rd_ptr_q];
  assign head_dbz = (head_dvs == '0);
  assign head_ovf = (head_dvd == MIN_VAL) && (head_dvs == '1);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dvd_q[wr_ptr_q] <= in_dividend;
      fifo_dvs_q[wr_ptr_q] <= in_divisor;
    end
  end

  // Power-of-two depth, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch FSM with registered outputs
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic                  div_start_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic                  dbz_q;
  logic                  ovf_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      div_start_q <= 1'b0;
      quot_q      <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            // The operand registers feed the divider directly. They change
            // only here, so they stay stable until the result is captured.
            opa_q <= head_dvd;
            opb_q <= head_dvs;
            if (head_dbz) begin
              quot_q      <= '0;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_RESULT;
            end else if (head_ovf) begin
              // The true quotient 2^(N-1) is not representable; the
              // dividend is returned as the wrapped result.
              quot_q      <= head_dvd;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_RESULT;
            end else begin
              // The start pulse is high for exactly the LAUNCH cycle.
              div_start_q <= 1'b1;
              state_q     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The divider drops div_complete on the start edge, so a high
          // value here always means this launch has finished.
          if (div_complete) begin
            quot_q      <= div_quotient;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_quotient = quot_q;
  assign out_dbz      = dbz_q;
  assign out_ovf      = ovf_q;
  assign div_start    = div_start_q;
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;
  assign dbg_state    = state_q;

`ifdef DIV_DISPATCH_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating handshake counters
  // -------------------------------------------------------------------------
  logic [31:0] stat_ops_q;
  logic [15:0] stat_dbz_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_ops_q <= '0;
      stat_dbz_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (stat_ops_q != '1)          stat_ops_q <= stat_ops_q + 32'd1;
      if (dbz_q && stat_dbz_q != '1) stat_dbz_q <= stat_dbz_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_dbz = stat_dbz_q;
`endif

endmodule

// File: tb/tb_div_dispatch.sv
// ---------------------------------------------------------------------------
// tb_div_dispatch
//
// Bench for div_dispatch. It contains a behavioural model of the attached
// iterative divider: div_complete drops on the start edge and rises
// DATA_WIDTH edges later. The expected results come from a reference model
// in 64-bit integer arithmetic and are kept in an expected queue.
// A latency is the count of rising edges from the edge that accepts the
// operands to the first edge at which out_valid is sampled high.
// ---------------------------------------------------------------------------
module tb_div_dispatch;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] MIN_VAL = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic          out_dbz;
  logic          out_ovf;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic [DW-1:0] div_quotient = '0;
  logic          div_complete = 1'b1;
  logic [1:0]    dbg_state;
`ifdef DIV_DISPATCH_STATS_EN
  logic [31:0]   stat_ops;
  logic [15:0]   stat_dbz;
`endif

  div_dispatch #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_dbz      (out_dbz),
    .out_ovf      (out_ovf),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_complete (div_complete),
`ifdef DIV_DISPATCH_STATS_EN
    .stat_ops     (stat_ops),
    .stat_dbz     (stat_dbz),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_push   = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {quotient, dbz, ovf} from plain integer rules.
  function automatic logic [DW+1:0] ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa;
    longint sb;
    longint q;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {{DW{1'b0}}, 2'b10};
    if (sa == -(longint'(1) <<< (DW - 1)) && sb == -1) return {a, 2'b01};
    q = sa / sb;  // integer division truncates toward zero
    return {q[DW-1:0], 2'b00};
  endfunction

  // ---------------- divider model ----------------
  logic [DW-1:0] lat_a = '0;
  logic [DW-1:0] lat_b = '0;
  int            div_cnt = 0;
  logic          div_busy = 1'b0;
  logic          ops_track = 1'b0;

  always @(posedge clock) begin
    if (div_start) begin
      lat_a        <= div_dividend;
      lat_b        <= div_divisor;
      div_cnt      <= DW;
      div_complete <= 1'b0;
      div_busy     <= 1'b1;
      ops_track    <= 1'b1;
      div_quotient <= $urandom;  // junk until the division finishes
    end else if (div_busy) begin
      if (div_cnt == 1) begin
        div_complete <= 1'b1;
        div_busy     <= 1'b0;
        div_quotient <= (lat_b == '0) ? '1 : DW'($signed(lat_a) / $signed(lat_b));
      end else begin
        div_cnt <= div_cnt - 1;
      end
    end
    if (!reset) ops_track <= 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic          hold_v = 1'b0;
  logic [DW+1:0] hold_val = '0;
  logic [DW+1:0] exp_val;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(in_dividend, in_divisor));
        n_push++;
      end
      if (div_start) n_start++;
      if (hold_v)
        check("hold_stable", {out_valid, out_quotient, out_dbz, out_ovf}, {1'b1, hold_val});
      if (out_valid && out_ready) begin
        got_q.push_back({out_quotient, out_dbz, out_ovf});
        check("result_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_val = exp_q.pop_front();
          check("result", {out_quotient, out_dbz, out_ovf}, exp_val);
        end
      end
      if (div_busy && ops_track)
        check("div_operands_stable", {div_dividend, div_divisor}, {lat_a, lat_b});
      hold_v   = out_valid && !out_ready;
      hold_val = {out_quotient, out_dbz, out_ovf};
    end
  end

  // Random consumer back-pressure, enabled only in the random phase.
  bit rand_ready = 1'b0;
  always @(posedge clock) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (entered and left at posedge + 1) -------
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input int budget, output bit ok);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_chk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit ok;
    push(a, b, 3000, ok);
    check("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic timed_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int lat, output logic [DW+1:0] res);
    bit seen;
    push_chk(a, b);
    seen = 1'b0;
    lat  = 0;
    res  = '0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
        res  = {out_quotient, out_dbz, out_ovf};
      end
      @(posedge clock);
      #1;
    end
    check("out_valid_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      done = (exp_q.size() == 0) && !out_valid;
      @(posedge clock);
      #1;
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  task automatic normal_operands(output logic [DW-1:0] a, output logic [DW-1:0] b);
    a = DW'(int'($urandom_range(0, 4000)) - 2000);
    b = DW'(int'($urandom_range(1, 60)));
    if ($urandom_range(0, 1) == 1) b = -b;
  endtask

  task automatic random_operands(output logic [DW-1:0] a, output logic [DW-1:0] b);
    case ($urandom_range(0, 9))
      0:       begin a = $urandom; b = '0; end
      1:       begin a = MIN_VAL;  b = '1; end
      2:       begin a = $urandom; b = $urandom; end
      3:       begin a = $urandom; b = DW'(int'($urandom_range(1, 5))); end
      default: normal_operands(a, b);
    endcase
  endtask

  // ---------------- main sequence ----------------
  int            lat;
  int            s0;
  int            p0;
  int            n_norm;
  int            seen_v;
  bit            ok;
  logic [DW+1:0] res;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic [DW+1:0] bp_exp[6];

  initial begin
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    reset       = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_quotient", 64'(out_quotient), 64'd0);
    check("rst_out_dbz", 64'(out_dbz), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_div_dividend", 64'(div_dividend), 64'd0);
    check("rst_div_divisor", 64'(div_divisor), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycles(1);
    @(negedge clock);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;

    // 100 / 7: one launch, full latency
    s0 = n_start;
    timed_op(32'd100, 32'd7, lat, res);
    check("t1_latency", 64'(lat), 64'd36);
    check("t1_result", 64'(res), {30'd0, 32'd14, 2'b00});
    wait_drain(200);
    check("t1_starts", 64'(n_start - s0), 64'd1);

    // -100/7 then 100/-7 back to back
    s0 = n_start;
    got_q.delete();
    push_chk(-32'sd100, 32'd7);
    push_chk(32'd100, -32'sd7);
    wait_drain(300);
    check("t2_count", 64'(got_q.size()), 64'd2);
    check("t2_first", 64'(got_q[0]), {30'd0, 32'hFFFF_FFF2, 2'b00});
    check("t2_second", 64'(got_q[1]), {30'd0, 32'hFFFF_FFF2, 2'b00});
    check("t2_starts", 64'(n_start - s0), 64'd2);

    // Bypass cases: no divider launch, result right after the pop
    s0 = n_start;
    timed_op(32'd5, 32'd0, lat, res);
    check("t3_dbz_latency", 64'(lat), 64'd2);
    check("t3_dbz_result", 64'(res), {30'd0, 32'd0, 2'b10});
    timed_op(MIN_VAL, 32'hFFFF_FFFF, lat, res);
    check("t3_ovf_latency", 64'(lat), 64'd2);
    check("t3_ovf_result", 64'(res), {30'd0, MIN_VAL, 2'b01});
    wait_drain(50);
    check("t3_starts", 64'(n_start - s0), 64'd0);

    // Back-pressure: one in flight plus a full FIFO, the sixth pair refused
    out_ready = 1'b0;
    got_q.delete();
    p0 = n_push;
    for (int i = 0; i < 6; i++) begin
      normal_operands(ra, rb);
      bp_exp[i] = ref_result(ra, rb);
      if (i < 5) begin
        push(ra, rb, 20, ok);
        check("t4_accepted", 64'(ok), 64'd1);
      end
    end
    push(ra, rb, 60, ok);
    check("t4_sixth_refused", 64'(ok), 64'd0);
    @(negedge clock);
    check("t4_in_ready_low", 64'(in_ready), 64'd0);
    check("t4_out_valid_held", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;
    check("t4_push_count", 64'(n_push - p0), 64'd5);
    out_ready = 1'b1;
    push_chk(ra, rb);
    wait_drain(1000);
    check("t4_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) check("t4_order", 64'(got_q[i]), 64'(bp_exp[i]));

    // Random operands with random consumer stalls
    s0 = n_start;
    n_norm = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      random_operands(ra, rb);
      if (ref_result(ra, rb) % 4 == 0) n_norm++;
      push_chk(ra, rb);
      cycles($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    cycles(2);
    out_ready = 1'b1;
    wait_drain(4000);
    check("t5_starts", 64'(n_start - s0), 64'(n_norm));

    // Reset while waiting on the divider
    push_chk(32'd1000, 32'd3);
    push_chk(32'd50, 32'd5);
    cycles(10);
    s0 = n_start;
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_in_ready_low", 64'(in_ready), 64'd0);
    check("t6_div_dividend", 64'(div_dividend), 64'd0);
    check("t6_div_start", 64'(div_start), 64'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t6_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    seen_v = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (out_valid) seen_v++;
      @(posedge clock);
      #1;
    end
    check("t6_no_stale_result", 64'(seen_v), 64'd0);
    check("t6_no_start", 64'(n_start - s0), 64'd0);
    timed_op(32'd9, 32'd3, lat, res);
    check("t6_latency", 64'(lat), 64'd36);
    check("t6_result", 64'(res), {30'd0, 32'd3, 2'b00});
    wait_drain(100);

`ifdef DIV_DISPATCH_STATS_EN
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    check("stat_ops_cleared", 64'(stat_ops), 64'd0);
    check("stat_dbz_cleared", 64'(stat_dbz), 64'd0);
    push_chk(32'd100, 32'd7);
    push_chk(32'd7, 32'd0);
    push_chk(-32'sd81, 32'd9);
    push_chk(32'd0, 32'd0);
    push_chk(32'd64, -32'sd8);
    wait_drain(500);
    check("stat_ops", 64'(stat_ops), 64'd5);
    check("stat_dbz", 64'(stat_dbz), 64'd2);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    @(negedge clock);
    check("stat_ops_reset", 64'(stat_ops), 64'd0);
    check("stat_dbz_reset", 64'(stat_dbz), 64'd0);
    @(posedge clock);
    #1;
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
Name: div_dispatch

Overview:
- Upstream scheduler for the iterative signed divider.
- Buffers signed dividend/divisor pairs from a valid/ready producer in a small FIFO and launches one division at a time on the divider's start/complete interface.
- Captures each quotient and presents it, with status flags, on a valid/ready result port.
- Handles divide-by-zero and the most-negative/-1 overflow case without issuing a divider operation.

Parameters:
- DATA_WIDTH, 32, operand and quotient width; must match the attached divider.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO not full.
- in_dividend  input  DATA_WIDTH  signed dividend.
- in_divisor  input  DATA_WIDTH  signed divisor.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- out_quotient  output  DATA_WIDTH  signed quotient.
- out_dbz  output  1  divisor was zero.
- out_ovf  output  1  dividend = minimum value and divisor = -1.
- div_start  output  1  one-cycle launch pulse to the divider.
- div_dividend  output  DATA_WIDTH  operand to the divider.
- div_divisor  output  DATA_WIDTH  operand to the divider.
- div_quotient  input  DATA_WIDTH  divider result.
- div_complete  input  1  divider idle/finished.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FIFO empties, FSM goes to IDLE.
  - in_ready=0 during reset, then 1 from the first cycle after reset deasserts.
  - out_valid=0, out_quotient=0, out_dbz=0, out_ovf=0.
  - div_start=0, div_dividend=0, div_divisor=0.
  - A division in flight is abandoned and its result is never presented.
- FIFO:
  - A push occurs when in_valid and in_ready are both 1.
  - in_ready = not full. A pop in the same cycle does not raise in_ready for that cycle.
  - Pointers wrap modulo FIFO_DEPTH. A separate count register of width clog2(FIFO_DEPTH)+1 tracks occupancy.
- FSM states: IDLE, LAUNCH, WAIT, RESULT.
- IDLE:
  - If the FIFO is non-empty and out_valid=0: pop the head into the operand registers.
  - If divisor==0: load out_quotient=0, out_dbz=1, go to RESULT.
  - Else if dividend==1 followed by all zeros and divisor==all ones: load out_quotient=dividend, out_ovf=1, go to RESULT.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - div_start=1 for exactly this cycle.
  - div_dividend and div_divisor are driven from the operand registers and stay stable until the RESULT capture.
  - The divider's output sign depends on these inputs, so they must not change before capture.
  - Next state is WAIT.
- WAIT:
  - Entered the cycle after start, when div_complete is already 0.
  - On div_complete=1, capture div_quotient into out_quotient, clear out_dbz and out_ovf, go to RESULT.
  - Expected dwell is DATA_WIDTH+1 cycles. No timeout.
- RESULT:
  - out_valid=1; outputs stay stable until out_ready=1.
  - On acceptance, out_valid drops the next cycle and the FSM returns to IDLE.
  - The next pop may occur in that IDLE cycle, giving at most one idle bubble per result.
- Latency for a normal op (push into an empty FIFO, out_ready held 1): in_valid accepted at cycle 0 → pop at cycle 1 → start at cycle 2 → out_valid at cycle 2+DATA_WIDTH+2 → 36 cycles at DATA_WIDTH=32.
- Bypass ops (dbz/ovf): out_valid the cycle after the pop.
- Push and pop in the same cycle when full: the push is refused (in_ready=0). When empty, a push is not visible to the pop until the next cycle (no fall-through).
- out_dbz and out_ovf are mutually exclusive.

Optional Feature:
- Macro: DIV_DISPATCH_STATS_EN.
- Enabled:
  - Adds outputs stat_ops (32-bit), incremented on every result handshake, and stat_dbz (16-bit), incremented on handshakes with out_dbz=1.
  - Both counters saturate at all ones and clear on reset.
- Disabled: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push 100/7 with out_ready=1 → one div_start pulse; out_quotient=14, dbz=0, ovf=0; out_valid 36 cycles after push.
- Push -100/7, then 100/-7 back-to-back → two ordered results 0xFFFFFFF2, 0xFFFFFFF2; exactly two start pulses.
- Push 5/0, then 0x80000000/0xFFFFFFFF → no div_start; results {0, dbz=1} then {0x80000000, ovf=1}, each out_valid one cycle after its pop.
- Hold out_ready=0 and push 6 pairs at FIFO_DEPTH=4 → in_ready=0 after 4 accepted plus 1 popped; result held stable. Releasing out_ready drains all 5 in order; the 6th is accepted only after in_ready returns.
- Assert reset=0 for one cycle mid-WAIT → out_valid=0, in_ready=0 during reset then 1, FIFO empty. The stale divider completion produces no result. The next push 9/3 yields 3.
- With DIV_DISPATCH_STATS_EN: 3 normal ops plus 2 dbz ops → stat_ops=5, stat_dbz=2; after reset both are 0.
